serializer: RTL and testbench

Return-path counterpart of the paralellizer. Collects encrypted result packets from the `NUM_ENCRYPTERS` encrypter lanes in strict round-robin order (the order the paralellizer dispatched them), and streams each packet out MSB-nibble-first over the 4-bit QSPI output interface toward the host. Sits between the encrypter array and the QSPI output pins.

---
 rtl/yoda_pkg.sv | 14 +
 rtl/nibble_piso.sv | 35 +++
 rtl/serializer.sv | 71 +++++++
 tb/tb_serializer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/yoda_pkg.sv
// yoda_pkg: constants and types shared by the paralellizer, encrypters and serializer.
// Debug watcher widths used under SERIALIZER_DEBUG_EN also come from here.
package yoda_pkg;
   localparam int NUM_ENCRYPTERS  = 4;
   localparam int ENCRYPTER_WIDTH = 32;
   localparam int NIBBLES         = ENCRYPTER_WIDTH / 4;
   localparam int IDX_W           = (NUM_ENCRYPTERS > 1) ? $clog2(NUM_ENCRYPTERS) : 1;
   localparam int NIB_W           = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   typedef enum logic [0:0] {S_WAIT = 1'b0, S_SHIFT = 1'b1} serializer_state_t;
   // explicit wrap so lane counts that are not a power of two still cycle correctly
   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
      return (i == IDX_W'(NUM_ENCRYPTERS - 1)) ? '0 : i + 1'b1;
   endfunction
endpackage

// File: rtl/nibble_piso.sv
// nibble_piso: parallel-in/serial-out shift register emitting MSB nibble first with a beat counter.
// SERIALIZER_DEBUG_EN exposes the beat counter as o_nib_cnt.
module nibble_piso import yoda_pkg::*; (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_clear,
   input  logic                       i_load,
   input  logic [ENCRYPTER_WIDTH-1:0] i_data,
   input  logic                       i_shift,
   output logic [3:0]                 o_nibble,
   output logic                       o_last
`ifdef SERIALIZER_DEBUG_EN
   ,output logic [NIB_W-1:0]          o_nib_cnt
`endif
);
   logic [ENCRYPTER_WIDTH-1:0] r_sr;
   logic [NIB_W-1:0]           r_cnt;
   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_sr  <= '0;
         r_cnt <= '0;
      end else if (i_load) begin
         r_sr  <= i_data;
         r_cnt <= '0;
      end else if (i_shift) begin
         r_sr  <= r_sr << 4;
         r_cnt <= o_last ? '0 : r_cnt + 1'b1;
      end
   end
   assign o_nibble = r_sr[ENCRYPTER_WIDTH-1 -: 4];
   assign o_last   = r_cnt == NIB_W'(NIBBLES - 1);
`ifdef SERIALIZER_DEBUG_EN
   assign o_nib_cnt = r_cnt;
`endif
endmodule

// File: rtl/serializer.sv
// serializer: collects encrypter results in strict round-robin lane order and streams them out over QSPI.
// Define SERIALIZER_DEBUG_EN to add state/index/packet watcher outputs.
module serializer import yoda_pkg::*; (
   input  logic                                           clk,
   input  logic                                           reset,
   input  logic                                           prog,
   input  logic [NUM_ENCRYPTERS-1:0][ENCRYPTER_WIDTH-1:0] encrypters_result,
   input  logic [NUM_ENCRYPTERS-1:0]                      encrypters_result_valid,
   output logic [NUM_ENCRYPTERS-1:0]                      encrypters_result_ack,
   output logic [3:0]                                     qspi_data,
   output logic                                           qspi_sending,
   input  logic                                           qspi_ready
`ifdef SERIALIZER_DEBUG_EN
   ,output logic [1:0]                                    state_out
   ,output logic [IDX_W-1:0]                              encrypter_index_out
   ,output logic [NIB_W-1:0]                              nibble_index_out
   ,output logic [ENCRYPTER_WIDTH-1:0]                    packet_out
`endif
);
   serializer_state_t         r_state, w_next;
   logic [IDX_W-1:0]          r_idx;
   logic [NUM_ENCRYPTERS-1:0] r_ack;
   logic                      w_cap, w_beat, w_last;
   logic [3:0]                w_nib;
`ifdef SERIALIZER_DEBUG_EN
   logic [NIB_W-1:0]          w_nib_cnt;
   logic [ENCRYPTER_WIDTH-1:0] r_packet;
`endif
   assign w_cap  = r_state == S_WAIT && encrypters_result_valid[r_idx];
   assign w_beat = r_state == S_SHIFT && qspi_ready;
   always_comb begin
      w_next = r_state;
      w_next = prog ? S_WAIT : w_cap ? S_SHIFT : (w_beat && w_last) ? S_WAIT : r_state;
   end
   always_ff @(posedge clk) begin
      r_state <= reset ? S_WAIT : w_next;
      r_ack   <= (reset || prog || !w_cap) ? '0 : NUM_ENCRYPTERS'(1) << r_idx;
      if (reset || prog)
         r_idx <= '0;
      else if (w_beat && w_last)
         r_idx <= next_idx(r_idx);
   end
   nibble_piso u_piso (
      .clk       (clk),
      .reset     (reset),
      .i_clear   (prog),
      .i_load    (w_cap),
      .i_data    (encrypters_result[r_idx]),
      .i_shift   (w_beat),
      .o_nibble  (w_nib),
      .o_last    (w_last)
`ifdef SERIALIZER_DEBUG_EN
      ,.o_nib_cnt(w_nib_cnt)
`endif
   );
   assign encrypters_result_ack = r_ack;
   assign qspi_sending          = r_state == S_SHIFT;
   assign qspi_data             = qspi_sending ? w_nib : 4'h0;
`ifdef SERIALIZER_DEBUG_EN
   always_ff @(posedge clk) begin
      if (reset)
         r_packet <= '0;
      else if (w_cap && !prog)
         r_packet <= encrypters_result[r_idx];
   end
   assign state_out           = 2'(r_state);
   assign encrypter_index_out = r_idx;
   assign nibble_index_out    = w_nib_cnt;
   assign packet_out          = r_packet;
`endif
endmodule

// File: tb/tb_serializer.sv
// tb_serializer: table-driven, directed and randomized checks of serializer against a packet-level model.
module tb_serializer;
   import yoda_pkg::*;
   logic clk = 0, reset = 1, prog = 0, qspi_ready = 1;
   logic [3:0][31:0] enc_res = '0;
   logic [3:0]       enc_valid = '0;
   logic [3:0]       enc_ack;
   logic [3:0]       qspi_data;
   logic             qspi_sending;
`ifdef SERIALIZER_DEBUG_EN
   logic [1:0]       dbg_state;
   logic [IDX_W-1:0] dbg_idx;
   logic [NIB_W-1:0] dbg_nib;
   logic [31:0]      dbg_pkt;
`endif
   always #5 clk = ~clk;
   serializer dut (
      .clk                    (clk),
      .reset                  (reset),
      .prog                   (prog),
      .encrypters_result      (enc_res),
      .encrypters_result_valid(enc_valid),
      .encrypters_result_ack  (enc_ack),
      .qspi_data              (qspi_data),
      .qspi_sending           (qspi_sending),
      .qspi_ready             (qspi_ready)
`ifdef SERIALIZER_DEBUG_EN
      ,.state_out             (dbg_state)
      ,.encrypter_index_out   (dbg_idx)
      ,.nibble_index_out      (dbg_nib)
      ,.packet_out            (dbg_pkt)
`endif
   );
   typedef struct {
      int          lane;
      logic [31:0] data;
      logic [31:0] mask;
      int          exp_sends;
   } vec_t;
   vec_t vt[5];
   int checks = 0, failures = 0;
   logic [31:0] lbuf [4][64];
   int lhead[4], ltail[4], mhead[4];
   int m_idx = 0, rx_n = 0, pkts = 0, sends = 0, acks = 0, hold_err = 0, ack_bad = 0;
   logic [31:0] rx_word = 0, last_word = 0, rmask = '1;
   bit rand_ready = 0;
   logic prev_send = 0, prev_ready = 0, prev_pr = 0;
   logic [3:0] prev_data = 0, prev_ack = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endfunction

   // encrypter lanes: each holds a queue of results and pops one when acked
   task automatic drive_enc();
      for (int l = 0; l < 4; l++) begin
         enc_valid[l] = lhead[l] < ltail[l];
         enc_res[l]   = enc_valid[l] ? lbuf[l][lhead[l]] : '0;
      end
   endtask

   task automatic push(input int l, input logic [31:0] d);
      lbuf[l][ltail[l]] = d;
      ltail[l]++;
      drive_enc();
   endtask

   // one cycle: sample outputs #1 after the edge, update the lane/host models, drive next inputs
   task automatic tick(input bit p = 0, input bit r = 0);
      @(posedge clk);
      #1;
      if ($countones(enc_ack) > 1 || (enc_ack & prev_ack) != 0) ack_bad++;
      for (int l = 0; l < 4; l++)
         if (enc_ack[l]) begin
            acks++;
            chk("ack_lane", l, m_idx);
            lhead[l]++;
         end
      prev_ack = enc_ack;
      drive_enc();
      if (prev_send && !prev_ready && !prev_pr && !(qspi_sending && qspi_data == prev_data)) hold_err++;
      if (qspi_sending) sends++;
      if (rand_ready)
         qspi_ready = $urandom_range(0, 3) != 0;
      else if (qspi_sending) begin
         qspi_ready = rmask[0];
         rmask      = {1'b1, rmask[31:1]};
      end else
         qspi_ready = 1;
      prog  = p;
      reset = r;
      if (p || r) begin
         m_idx = 0;
         rx_n  = 0;
         for (int l = 0; l < 4; l++) mhead[l] = lhead[l];
      end else if (qspi_sending && qspi_ready) begin
         rx_word = {rx_word[27:0], qspi_data};
         rx_n++;
         if (rx_n == 8) begin
            checks++;
            if (mhead[m_idx] >= ltail[m_idx] || rx_word != lbuf[m_idx][mhead[m_idx]]) begin
               failures++;
               $display("FAIL packet lane=%0d actual=%h required=%h", m_idx, rx_word,
                        (mhead[m_idx] < ltail[m_idx]) ? lbuf[m_idx][mhead[m_idx]] : 32'hx);
            end
            mhead[m_idx]++;
            m_idx     = (m_idx + 1) % 4;
            pkts++;
            last_word = rx_word;
            rx_n      = 0;
         end
      end
      prev_send  = qspi_sending;
      prev_ready = qspi_ready;
      prev_data  = qspi_data;
      prev_pr    = p || r;
   endtask

   task automatic wait_pkts(input int n, input int budget, input string name);
      int p0, k;
      p0 = pkts;
      k  = 0;
      while (pkts < p0 + n && k < budget) begin
         tick();
         k++;
      end
      chk({name, "_done"}, pkts - p0, n);
   endtask

   initial begin
      int s0, a0, h0, k, nx;
      logic [16:0] hist;
      int ord[24];
      vt[0] = '{lane: 0, data: 32'hDEADBEEF, mask: 32'hFFFFFFFF, exp_sends: 8};
      vt[1] = '{lane: 1, data: 32'hDEADBEEF, mask: 32'hFFFFFFDD, exp_sends: 10};
      vt[2] = '{lane: 2, data: 32'hA2222222, mask: 32'hFFFFFFFE, exp_sends: 9};
      vt[3] = '{lane: 3, data: 32'hA3333333, mask: 32'hFFFFFF7F, exp_sends: 9};
      vt[4] = '{lane: 0, data: 32'hA0000000, mask: 32'hFFFFFFFF, exp_sends: 8};
      drive_enc();
      tick(0, 1);
      chk("reset_sending", qspi_sending, 0);
      chk("reset_data", qspi_data, 0);
      chk("reset_ack", enc_ack, 0);
      tick();
      for (int i = 0; i < 5; i++) begin
         s0    = sends;
         a0    = acks;
         h0    = hold_err;
         rmask = vt[i].mask;
         push(vt[i].lane, vt[i].data);
         wait_pkts(1, 40, "row");
         chk("row_word", last_word, vt[i].data);
         chk("row_sends", sends - s0, vt[i].exp_sends);
         chk("row_acks", acks - a0, 1);
         chk("row_hold", hold_err - h0, 0);
         tick();
         chk("row_gap", qspi_sending, 0);
      end
      // back-to-back packets: 8 sending, 1 idle, 8 sending
      rmask = '1;
      push(1, $urandom);
      push(2, $urandom);
      k = 0;
      while (!qspi_sending && k < 10) begin
         tick();
         k++;
      end
      for (int i = 0; i < 17; i++) begin
         hist[i] = qspi_sending;
         tick();
      end
      chk("throughput", hist, 17'h1FEFF);
      // strict ordering: lane 2 must wait for lanes 0 and 1
      tick(1);
      s0 = sends;
      a0 = acks;
      push(2, 32'h22222222);
      repeat (20) tick();
      chk("order_quiet_send", sends - s0, 0);
      chk("order_quiet_ack", acks - a0, 0);
      push(0, 32'h00000000);
      repeat (3) tick();
      push(1, 32'h11111111);
      wait_pkts(3, 80, "order");
      chk("order_last", last_word, 32'h22222222);
      // wrap: four lanes then lane 0 again
      tick(1);
      push(0, 32'hA0000000);
      push(1, 32'hA1111111);
      push(2, 32'hA2222222);
      push(3, 32'hA3333333);
      push(0, 32'h5A5A5A5A);
      wait_pkts(5, 100, "wrap");
      chk("wrap_last", last_word, 32'h5A5A5A5A);
      // prog after 3 accepted nibbles of the lane-1 packet
      push(1, 32'h12345678);
      push(2, 32'h9ABCDEF0);
      push(0, 32'h0F0F0F0F);
      k = 0;
      while (rx_n < 3 && k < 30) begin
         tick();
         k++;
      end
      tick(1);
      tick();
      chk("prog_idle", qspi_sending, 0);
      k = 0;
      while (enc_ack == 0 && k < 10) begin
         tick();
         k++;
      end
      chk("prog_next_lane", enc_ack, 4'b0001);
      push(1, 32'h11112222);
      wait_pkts(3, 60, "prog");
      chk("prog_last", last_word, 32'h9ABCDEF0);
      // reset mid-shift
      push(3, 32'h33334444);
      k = 0;
      while (rx_n < 4 && k < 30) begin
         tick();
         k++;
      end
      tick(0, 1);
      tick();
      chk("midreset_sending", qspi_sending, 0);
      chk("midreset_data", qspi_data, 0);
      chk("midreset_ack", enc_ack, 0);
      push(0, 32'hCAFEF00D);
      wait_pkts(1, 40, "midreset");
      chk("midreset_last", last_word, 32'hCAFEF00D);
      // randomized traffic with random host backpressure
      tick(1);
      for (int i = 0; i < 24; i++) ord[i] = i % 4;
      for (int i = 23; i > 0; i--) begin
         int j, t;
         j      = $urandom_range(0, i);
         t      = ord[i];
         ord[i] = ord[j];
         ord[j] = t;
      end
      rand_ready = 1;
      s0 = pkts;
      nx = 0;
      k  = 0;
      while (pkts - s0 < 24 && k < 3000) begin
         if (nx < 24 && $urandom_range(0, 3) == 0) begin
            push(ord[nx], $urandom);
            nx++;
         end
         tick();
         k++;
      end
      rand_ready = 0;
      chk("random_pkts", pkts - s0, 24);
      chk("ack_pulse", ack_bad, 0);
      chk("hold_total", hold_err, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
